// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction fetch stage and its IF/ID register.
package if_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DROP
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: valid bit, instruction word and the address following it.
// Flush wins over load; with neither asserted the contents are held.
module if_stage_if_id_reg #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic                i_flush,
  input  logic [31:0]         i_instr,
  input  logic [PC_WIDTH-1:0] i_pc4,
  output logic                o_valid,
  output logic [31:0]         o_instr,
  output logic [PC_WIDTH-1:0] o_pc4
);

  logic                r_valid;
  logic [31:0]         r_instr;
  logic [PC_WIDTH-1:0] r_pc4;

  // A flush turns the slot into a bubble; the stale pc4 is left in place because nothing reads it while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, runs the req/ack fetch handshake with instruction
// memory, and feeds the IF/ID register whose opcode/func fields go straight to decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned          PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = PC_WIDTH'(RESET_PC_DEFAULT),
  parameter logic [31:0]          NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic                ifid_valid,
  output logic [31:0]         ifid_instr,
  output logic [PC_WIDTH-1:0] ifid_pc4,
  output logic [5:0]          ifid_opcode,
  output logic [5:0]          ifid_func
);

  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

  state_e              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_reqAddr;
  logic                r_imemReq;
  logic [31:0]         r_holdBuf;

  logic [PC_WIDTH-1:0] w_redirPc;
  logic [PC_WIDTH-1:0] w_reqAddrP4;
  logic                w_ifidLoad;
  logic                w_ifidFlush;
  logic [31:0]         w_ifidInstr;
  logic [PC_WIDTH-1:0] w_ifidPc4;

  // Redirect targets are word aligned by masking, and the next sequential address wraps naturally.
  assign w_redirPc   = redirect_pc & ALIGN_MASK;
  assign w_reqAddrP4 = r_reqAddr + PC_STEP;

  // Decide what the IF/ID register does this cycle: flush (redirect or bubble), load, or hold.
  always_comb begin
    w_ifidLoad  = 1'b0;
    w_ifidFlush = 1'b0;
    w_ifidInstr = imem_rdata;
    w_ifidPc4   = w_reqAddrP4;
    unique case (r_state)
      S_IDLE: begin
        w_ifidFlush = redirect;
      end
      S_REQ: begin
        if (redirect) begin
          w_ifidFlush = 1'b1;
        end else if (imem_ack) begin
          w_ifidLoad = !stall;
        end else begin
          w_ifidFlush = !stall;
        end
      end
      S_HOLD: begin
        w_ifidInstr = r_holdBuf;
        w_ifidPc4   = r_pc;
        if (redirect) begin
          w_ifidFlush = 1'b1;
        end else begin
          w_ifidLoad = !stall;
        end
      end
      S_DROP: begin
        w_ifidFlush = redirect || !stall;
      end
      default: begin
        w_ifidFlush = 1'b1;
      end
    endcase
  end

  // Fetch FSM: PC, outstanding request address, hold buffer and the registered request line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_reqAddr <= RESET_PC;
      r_imemReq <= 1'b0;
      r_holdBuf <= NOP_INSTR;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_state   <= S_REQ;
          r_imemReq <= 1'b1;
          if (redirect) begin
            r_pc      <= w_redirPc;
            r_reqAddr <= w_redirPc;
          end else begin
            r_reqAddr <= r_pc;
          end
        end
        S_REQ: begin
          if (redirect) begin
            r_pc <= w_redirPc;
            if (imem_ack) begin
              r_reqAddr <= w_redirPc;
            end else begin
              r_state <= S_DROP;
            end
          end else if (imem_ack) begin
            r_pc <= w_reqAddrP4;
            if (stall) begin
              r_holdBuf <= imem_rdata;
              r_state   <= S_HOLD;
              r_imemReq <= 1'b0;
            end else begin
              r_reqAddr <= w_reqAddrP4;
            end
          end
        end
        S_HOLD: begin
          if (redirect) begin
            r_pc      <= w_redirPc;
            r_reqAddr <= w_redirPc;
            r_holdBuf <= NOP_INSTR;
            r_state   <= S_REQ;
            r_imemReq <= 1'b1;
          end else if (!stall) begin
            r_reqAddr <= r_pc;
            r_state   <= S_REQ;
            r_imemReq <= 1'b1;
          end
        end
        S_DROP: begin
          if (redirect) begin
            r_pc <= w_redirPc;
          end
          if (imem_ack) begin
            r_reqAddr <= redirect ? w_redirPc : r_pc;
            r_state   <= S_REQ;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_imemReq <= 1'b0;
        end
      endcase
    end
  end

  if_stage_if_id_reg #(
    .PC_WIDTH (PC_WIDTH),
    .NOP_INSTR(NOP_INSTR)
  ) u_ifIdReg (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_ifidLoad),
    .i_flush(w_ifidFlush),
    .i_instr(w_ifidInstr),
    .i_pc4  (w_ifidPc4),
    .o_valid(ifid_valid),
    .o_instr(ifid_instr),
    .o_pc4  (ifid_pc4)
  );

  assign imem_req    = r_imemReq;
  assign imem_addr   = r_reqAddr;
  assign ifid_opcode = ifid_instr[OPCODE_MSB:OPCODE_LSB];
  assign ifid_func   = ifid_instr[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage with a latency-programmable instruction memory model.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [5:0]  ifid_opcode;
  logic [5:0]  ifid_func;

  logic [31:0] mem [256];
  int          memLatency;
  int          waitCnt;
  logic        prevReq;
  int          checkCount;
  int          failCount;

  if_stage #(
    .PC_WIDTH (32),
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ifid_valid (ifid_valid),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4),
    .ifid_opcode(ifid_opcode),
    .ifid_func  (ifid_func)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: acks a request once it has waited memLatency cycles; latency 0 acks in the request cycle.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    waitCnt    = 0;
    prevReq    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !imem_req) begin
        waitCnt    = 0;
        prevReq    = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
      end else begin
        if (prevReq && !imem_ack) waitCnt++;
        else waitCnt = 0;
        prevReq    = 1'b1;
        imem_ack   = (waitCnt >= memLatency);
        imem_rdata = imem_ack ? mem[imem_addr[9:2]] : 32'hDEAD_BEEF;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic iStall, input logic iRedirect, input logic [31:0] iRpc);
    stall       = iStall;
    redirect    = iRedirect;
    redirect_pc = iRpc;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkIfid(input string tag, input logic iValid, input logic [31:0] iInstr, input logic [31:0] iPc4);
    checkOutput({tag, "_valid"}, 32'(ifid_valid), 32'(iValid));
    checkOutput({tag, "_instr"}, ifid_instr, iInstr);
    checkOutput({tag, "_pc4"}, ifid_pc4, iPc4);
  endtask

  task automatic checkFetch(input string tag, input logic iReq, input logic [31:0] iAddr);
    checkOutput({tag, "_req"}, 32'(imem_req), 32'(iReq));
    checkOutput({tag, "_addr"}, imem_addr, iAddr);
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    memLatency = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | (i << 2);
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h0109_5020;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    tick();

    $display("[TB] reset values");
    checkFetch("rst", 1'b0, 32'h0);
    checkIfid("rst", 1'b0, 32'h0, 32'h0);
    rst = 1'b0;

    $display("[TB] sequential fetch, zero latency");
    tick();
    checkFetch("seq0", 1'b1, 32'h0);
    checkOutput("seq0_valid", 32'(ifid_valid), 32'h0);
    tick();
    checkFetch("seq1", 1'b1, 32'h4);
    checkIfid("seq1", 1'b1, 32'h2008_0005, 32'h4);
    checkOutput("seq1_opcode", 32'(ifid_opcode), 32'h08);
    tick();
    checkFetch("seq2", 1'b1, 32'h8);
    checkIfid("seq2", 1'b1, 32'h0109_5020, 32'h8);
    checkOutput("seq2_opcode", 32'(ifid_opcode), 32'h00);
    checkOutput("seq2_func", 32'(ifid_func), 32'h20);

    $display("[TB] stall while fetch at 0x8 is acked");
    applyStimulus(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_req", 32'(imem_req), 32'h0);
      checkIfid("stall", 1'b1, 32'h0109_5020, 32'h8);
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick();
    checkFetch("release", 1'b1, 32'hC);
    checkIfid("release", 1'b1, 32'h1000_0008, 32'hC);
    tick();
    checkFetch("after_release", 1'b1, 32'h10);
    checkIfid("after_release", 1'b1, 32'h1000_000C, 32'h10);

    $display("[TB] redirect during a latency-3 fetch");
    memLatency = 3;
    tick();
    checkFetch("lat_issue", 1'b1, 32'h14);
    checkIfid("lat_issue", 1'b1, 32'h1000_0010, 32'h14);
    checkOutput("lat_issue_ack", 32'(imem_ack), 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h40);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkFetch("drop0", 1'b1, 32'h14);
    checkIfid("drop0", 1'b0, 32'h0, 32'h14);
    tick();
    checkFetch("drop1", 1'b1, 32'h14);
    checkOutput("drop1_valid", 32'(ifid_valid), 32'h0);
    tick();
    checkFetch("drop2", 1'b1, 32'h14);
    checkOutput("drop2_ack", 32'(imem_ack), 32'h1);
    tick();
    checkFetch("redir_addr", 1'b1, 32'h40);
    checkOutput("redir_valid", 32'(ifid_valid), 32'h0);
    checkOutput("redir_instr", ifid_instr, 32'h0);
    tick();
    tick();
    tick();
    checkOutput("redir_wait_valid", 32'(ifid_valid), 32'h0);
    memLatency = 0;
    tick();
    checkFetch("redir_fetch", 1'b1, 32'h44);
    checkIfid("redir_fetch", 1'b1, 32'h1000_0040, 32'h44);

    $display("[TB] redirect together with stall, unaligned target");
    applyStimulus(1'b1, 1'b1, 32'h103);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkFetch("rs", 1'b1, 32'h100);
    checkOutput("rs_valid", 32'(ifid_valid), 32'h0);
    checkOutput("rs_instr", ifid_instr, 32'h0);
    tick();
    checkIfid("rs_next", 1'b1, 32'h1000_0100, 32'h104);

    $display("[TB] redirect to top of address space");
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkFetch("wrap0", 1'b1, 32'hFFFF_FFFC);
    checkOutput("wrap0_valid", 32'(ifid_valid), 32'h0);
    tick();
    checkFetch("wrap1", 1'b1, 32'h0);
    checkIfid("wrap1", 1'b1, 32'h1000_03FC, 32'h0);
    tick();
    checkIfid("wrap2", 1'b1, 32'h2008_0005, 32'h4);

    $display("[TB] reset while holding a buffered instruction");
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("hold_req", 32'(imem_req), 32'h0);
    checkIfid("hold", 1'b1, 32'h2008_0005, 32'h4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkFetch("rst2", 1'b0, 32'h0);
    checkIfid("rst2", 1'b0, 32'h0, 32'h0);
    tick();
    checkFetch("rst2_req", 1'b1, 32'h0);
    checkOutput("rst2_req_valid", 32'(ifid_valid), 32'h0);
    tick();
    checkIfid("rst2_first", 1'b1, 32'h2008_0005, 32'h4);
    checkFetch("rst2_next", 1'b1, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
